// File: rtl/shift_counter_gen.sv
// Parametrised Johnson/ring shift counter with load, direction, index, wrap and illegal-state flags.
// Optional self-correction of illegal results is enabled by defining SHIFT_COUNTER_SELF_CORRECT_EN.
module shift_counter_gen #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             illegal,
  output logic             corrected
);

  logic             mode_q;
  logic [WIDTH-1:0] dout_n;
  logic [IW-1:0]    idx_n;
  logic             wrap_n;
  logic             corr_n;
  logic [WIDTH-1:0] cand;
  logic             write;
  logic [IW:0]      cur_dec;
  logic [IW:0]      cand_dec;
  logic [IW-1:0]    last;

  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    return m ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
  endfunction

  // Sequence pattern at position k of the given mode.
  function automatic logic [WIDTH-1:0] pattern_of(input logic m, input int unsigned k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (m) return seed_of(1'b1) >> k;
    if (k <= WIDTH) return ~(ones >> k);
    return ones >> (k - WIDTH);
  endfunction

  // Returns {legal, position}; position is 0 for an illegal value.
  function automatic logic [IW:0] decode(input logic [WIDTH-1:0] v, input logic m);
    logic [IW:0] r;
    r = '0;
    for (int unsigned k = 0; k < 2 * WIDTH; k++) begin
      if ((!m || k < WIDTH) && v == pattern_of(m, k)) r = {1'b1, IW'(k)};
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v, input logic m,
                                               input logic d);
    logic fill;
    if (d) begin
      fill = m ? v[WIDTH-1] : ~v[WIDTH-1];
      return {v[WIDTH-2:0], fill};
    end
    fill = m ? v[0] : ~v[0];
    return {fill, v[WIDTH-1:1]};
  endfunction

  // Next-state selection: mode reinit, then load, then step, else hold.
  always_comb begin
    dout_n   = dout;
    idx_n    = idx;
    wrap_n   = 1'b0;
    corr_n   = 1'b0;
    cand     = dout;
    write    = 1'b0;
    cur_dec  = decode(dout, mode);
    illegal  = ~cur_dec[IW];
    last     = mode_q ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);

    if (mode != mode_q) begin
      dout_n = seed_of(mode);
      idx_n  = '0;
    end else if (load) begin
      cand  = load_val;
      write = 1'b1;
    end else if (en) begin
      cand   = step_of(dout, mode_q, dir);
      write  = 1'b1;
      wrap_n = cur_dec[IW] && (dir ? (idx == '0) : (idx == last));
    end

    cand_dec = decode(cand, mode_q);
    if (write) begin
      dout_n = cand;
      idx_n  = cand_dec[IW-1:0];
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
      if (!cand_dec[IW]) begin
        dout_n = seed_of(mode_q);
        idx_n  = '0;
        corr_n = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= seed_of(mode);
      idx       <= '0;
      wrap      <= 1'b0;
      corrected <= 1'b0;
      mode_q    <= mode;
    end else begin
      dout      <= dout_n;
      idx       <= idx_n;
      wrap      <= wrap_n;
      corrected <= corr_n;
      mode_q    <= mode;
    end
  end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench for shift_counter_gen: directed vector table, hand sequences and
// randomized traffic against a position-based reference model.
module tb_shift_counter_gen;

  localparam int W  = 4;
  localparam int IW = $clog2(2 * W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic          dir = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  dout;
  logic [IW-1:0] idx;
  logic          wrap;
  logic          illegal;
  logic          corrected;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_counter_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .dout(dout), .idx(idx), .wrap(wrap), .illegal(illegal),
    .corrected(corrected)
  );

  // Reference model: sequence position plus a raw value for illegal states.
  int m_mode, m_pos, m_raw;
  bit m_legal, m_wrap, m_corr;

  function automatic int pat(input int md, input int k);
    if (md != 0) return 1 << (W - 1 - k);
    if (k <= W) return ((1 << k) - 1) << (W - k);
    return (1 << (2 * W - k)) - 1;
  endfunction

  function automatic int find(input int md, input int v);
    int n = (md != 0) ? W : 2 * W;
    for (int k = 0; k < n; k++) if (pat(md, k) == v) return k;
    return -1;
  endfunction

  function automatic int raw_step(input int md, input int d, input int v);
    int mask = (1 << W) - 1;
    int msb  = (v >> (W - 1)) & 1;
    int lsb  = v & 1;
    if (md != 0)
      return d ? (((v << 1) & mask) | msb) : ((v >> 1) | (lsb << (W - 1)));
    return d ? (((v << 1) & mask) | (1 - msb)) : ((v >> 1) | ((1 - lsb) << (W - 1)));
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit md, input bit d,
                            input bit l, input int lv);
    int n, f;
    m_wrap = 0;
    m_corr = 0;
    if (r || md != m_mode) begin
      m_mode = md; m_pos = 0; m_legal = 1;
    end else if (l) begin
      f = find(md, lv);
      if (f >= 0) begin
        m_legal = 1; m_pos = f;
      end else begin
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
        m_legal = 1; m_pos = 0; m_corr = 1;
`else
        m_legal = 0; m_raw = lv; m_pos = 0;
`endif
      end
    end else if (e) begin
      n = (m_mode != 0) ? W : 2 * W;
      if (m_legal) begin
        m_wrap = d ? (m_pos == 0) : (m_pos == n - 1);
        m_pos  = d ? (m_pos + n - 1) % n : (m_pos + 1) % n;
      end else begin
        m_raw = raw_step(m_mode, d, m_raw);
        f = find(m_mode, m_raw);
        if (f >= 0) begin
          m_legal = 1; m_pos = f;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge with the given inputs; all outputs compared with the model.
  task automatic apply(input bit r, input bit e, input bit md, input bit d,
                       input bit l, input logic [W-1:0] lv);
    int exp_dout;
    rst = r; en = e; mode = md; dir = d; load = l; load_val = lv;
    @(posedge clk);
    #1;
    model_edge(r, e, md, d, l, int'(lv));
    exp_dout = m_legal ? pat(m_mode, m_pos) : m_raw;
    check("model_dout", 32'(dout), 32'(exp_dout));
    check("model_idx", 32'(idx), 32'(m_legal ? m_pos : 0));
    check("model_wrap", 32'(wrap), 32'(m_wrap));
    check("model_corrected", 32'(corrected), 32'(m_corr));
    check("model_illegal", 32'(illegal), 32'(find(md, exp_dout) < 0));
  endtask

  typedef struct {
    bit           rst, en, mode, dir, load;
    logic [W-1:0] lv;
    logic [W-1:0] dout;
    int           idx;
    bit           wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit e, input bit md, input bit d, input bit l,
                     input logic [W-1:0] lv, input logic [W-1:0] dv, input int ix,
                     input bit wr);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.dir = d; v.load = l; v.lv = lv;
    v.dout = dv; v.idx = ix; v.wrap = wr;
    tbl.push_back(v);
  endtask

  initial begin
    bit md_r;
    // Johnson forward from reset, full cycle with wrap, then hold
    add(1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1100, 2, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1110, 3, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b0111, 5, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b0011, 6, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 7, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1);
    add(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // Johnson backward: wrap on 0 -> 7
    add(0, 1, 0, 1, 0, 4'b0000, 4'b0001, 7, 1);
    add(0, 1, 0, 1, 0, 4'b0000, 4'b0011, 6, 0);
    add(0, 1, 0, 1, 0, 4'b0000, 4'b0111, 5, 0);
    // Reset at idx 5 with en high, then resume
    add(1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 0);
    // Ring mode
    add(1, 0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 4'b0010, 2, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 3, 0);
    add(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 1);
    add(0, 1, 1, 0, 0, 4'b0000, 4'b0100, 1, 0);
    // Mode toggle mid-run reinitialises, beating en
    add(0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // Load with en: load wins, then step
    add(0, 1, 0, 0, 1, 4'b1110, 4'b1110, 3, 0);
    add(0, 1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0);
    // Mode change beats load; ring backward wrap
    add(0, 0, 1, 0, 1, 4'b0010, 4'b1000, 0, 0);
    add(0, 1, 1, 1, 0, 4'b0000, 4'b0001, 3, 1);
    add(0, 0, 1, 0, 1, 4'b0010, 4'b0010, 2, 0);

    #2;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].dir, tbl[i].load, tbl[i].lv);
      check($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
      check($sformatf("vec%0d_idx", i), 32'(idx), 32'(tbl[i].idx));
      check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
    end

    // Illegal load 1010 in Johnson mode
    apply(1, 0, 0, 0, 0, 4'b0000);
    apply(0, 0, 0, 0, 1, 4'b1010);
`ifdef SHIFT_COUNTER_SELF_CORRECT_EN
    check("bad_load_dout", 32'(dout), 32'(4'b0000));
    check("bad_load_corrected", 32'(corrected), 32'(1));
    check("bad_load_illegal", 32'(illegal), 32'(0));
    apply(0, 0, 0, 0, 0, 4'b0000);
    check("bad_load_corr_pulse", 32'(corrected), 32'(0));
`else
    check("bad_load_dout", 32'(dout), 32'(4'b1010));
    check("bad_load_idx", 32'(idx), 32'(0));
    check("bad_load_illegal", 32'(illegal), 32'(1));
    apply(0, 1, 0, 0, 0, 4'b0000);
    check("bad_step_dout", 32'(dout), 32'(4'b1101));
    check("bad_step_illegal", 32'(illegal), 32'(1));
    check("bad_step_idx", 32'(idx), 32'(0));
`endif

    // illegal follows the mode input combinationally before the reinit edge
    apply(1, 0, 0, 0, 0, 4'b0000);
    mode = 1'b1;
    #1;
    check("illegal_comb_mode", 32'(illegal), 32'(1));
    apply(0, 0, 1, 0, 0, 4'b0000);
    check("reinit_ring_dout", 32'(dout), 32'(4'b1000));
    check("reinit_ring_illegal", 32'(illegal), 32'(0));

    // Randomized traffic against the model
    md_r = 1'b0;
    apply(1, 0, md_r, 0, 0, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      bit r, e, d, l;
      if ($urandom_range(19) == 0) md_r = ~md_r;
      r = ($urandom_range(49) == 0);
      e = ($urandom_range(9) < 7);
      d = 1'($urandom_range(1));
      l = ($urandom_range(7) == 0);
      apply(r, e, md_r, d, l, W'($urandom_range((1 << W) - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
